// File: rtl/top_9x1_arbiter.sv
// top_9x1_arbiter: nine per-channel byte FIFOs merged into one registered
// output through a round-robin arbiter. Build option: define
// TOP_9X1_FREEZE_EN to drive the freeze_clk requests; when it is undefined
// freeze_clk is tied to zero.
//
// Handshake: valid means o_data holds an unconsumed word; a word is consumed
// on a rising edge where valid=1 and ren=1. The output register is refilled
// on that same edge when any FIFO has data, so there is no bubble.
module top_9x1_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic [8:0]  wen,
  input  logic [7:0]  i_data0,
  input  logic [7:0]  i_data1,
  input  logic [7:0]  i_data2,
  input  logic [7:0]  i_data3,
  input  logic [7:0]  i_data4,
  input  logic [7:0]  i_data5,
  input  logic [7:0]  i_data6,
  input  logic [7:0]  i_data7,
  input  logic [7:0]  i_data8,
  input  logic        ren,
  output logic        valid,
  output logic [7:0]  o_data,
  output logic [12:0] freeze_clk
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0] w_din [9];
  logic [7:0] w_head [9];
  logic [8:0] w_nonempty;
  logic [8:0] w_full;
  logic [8:0] w_push;
  logic [8:0] w_pop;
  logic       w_any;
  logic [3:0] w_sel;
  logic [4:0] w_idx;
  logic       w_load;

  logic       r_valid;
  logic [7:0] r_data;
  logic [3:0] r_last;

  assign w_din[0] = i_data0;
  assign w_din[1] = i_data1;
  assign w_din[2] = i_data2;
  assign w_din[3] = i_data3;
  assign w_din[4] = i_data4;
  assign w_din[5] = i_data5;
  assign w_din[6] = i_data6;
  assign w_din[7] = i_data7;
  assign w_din[8] = i_data8;

  for (genvar g = 0; g < 9; g++) begin : g_fifo
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Storage array: written at the write pointer on an accepted push.
    always_ff @(posedge clk_i) begin
      if (w_push[g]) r_mem[r_wptr] <= w_din[g];
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push[g]) r_wptr <= r_wptr + PW'(1);
        if (w_pop[g])  r_rptr <= r_rptr + PW'(1);
        r_count <= r_count + CW'(w_push[g]) - CW'(w_pop[g]);
      end
    end

    assign w_nonempty[g] = (r_count != '0);
    assign w_full[g]     = (r_count == CW'(DEPTH));
    assign w_head[g]     = r_mem[r_rptr];
  end

  // Round-robin pick: first non-empty channel after the last grant, mod 9.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int i = 1; i <= 9; i++) begin
      w_idx = {1'b0, r_last} + 5'(i);
      if (w_idx >= 5'd9) w_idx = w_idx - 5'd9;
      if (!w_any && w_nonempty[w_idx[3:0]]) begin
        w_any = 1'b1;
        w_sel = w_idx[3:0];
      end
    end
  end

  assign w_load = (!r_valid || ren) && w_any;
  assign w_pop  = w_load ? (9'b1 << w_sel) : 9'b0;
  // A full FIFO still accepts a push when it is popped on the same edge.
  assign w_push = wen & (~w_full | w_pop);

  // Output stage: load on free/accepted slot, otherwise clear or hold.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_last  <= 4'd8;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_head[w_sel];
      r_last  <= w_sel;
    end else if (r_valid && ren) begin
      r_valid <= 1'b0;
    end
  end

  assign valid  = r_valid;
  assign o_data = r_data;

`ifdef TOP_9X1_FREEZE_EN
  assign freeze_clk = {r_valid & ~ren, 3'b000, w_full};
`else
  assign freeze_clk = 13'h0000;
`endif

endmodule

// File: tb/tb_top_9x1_arbiter.sv
// Bench for top_9x1_arbiter: directed scenarios followed by random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_top_9x1_arbiter;

  localparam int DEPTH = 4;
`ifdef TOP_9X1_FREEZE_EN
  localparam logic F_EN = 1'b1;
`else
  localparam logic F_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk_i = 1'b0;
  logic        reset_n;
  logic [8:0]  wen;
  logic [7:0]  din [9];
  logic        ren;
  logic        valid;
  logic [7:0]  o_data;
  logic [12:0] freeze_clk;

  always #5 clk_i = ~clk_i;

  top_9x1_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .reset_n    (reset_n),
    .wen        (wen),
    .i_data0    (din[0]),
    .i_data1    (din[1]),
    .i_data2    (din[2]),
    .i_data3    (din[3]),
    .i_data4    (din[4]),
    .i_data5    (din[5]),
    .i_data6    (din[6]),
    .i_data7    (din[7]),
    .i_data8    (din[8]),
    .ren        (ren),
    .valid      (valid),
    .o_data     (o_data),
    .freeze_clk (freeze_clk)
  );

  // ---------------- scoreboard state ----------------
  int          n_pass  = 0;
  int          n_total = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  mq [9][$];
  logic        m_valid;
  logic [7:0]  m_data;
  int          m_last;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int k = 0; k < 9; k++) mq[k].delete();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_last  = 8;
  endtask

  function automatic logic [12:0] model_freeze();
    logic [12:0] f;
    f = '0;
    if (F_EN) begin
      for (int k = 0; k < 9; k++) f[k] = (mq[k].size() == DEPTH);
      f[12] = m_valid & ~ren;
    end
    return f;
  endfunction

  // One rising edge of the ideal merger, from the inputs present at the edge.
  task automatic model_edge();
    int  sel;
    bit  any;
    any = 0;
    sel = 0;
    for (int i = 1; i <= 9; i++) begin
      int c;
      c = (m_last + i) % 9;
      if (!any && mq[c].size() > 0) begin
        any = 1;
        sel = c;
      end
    end
    if ((!m_valid || ren) && any) begin
      m_data  = mq[sel].pop_front();
      m_valid = 1'b1;
      m_last  = sel;
    end else if (m_valid && ren) begin
      m_valid = 1'b0;
    end
    for (int k = 0; k < 9; k++)
      if (wen[k] && mq[k].size() < DEPTH) mq[k].push_back(din[k]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    chk("valid", 16'(valid), 16'(m_valid));
    chk("o_data", 16'(o_data), 16'(m_data));
    chk("freeze_clk", 16'(freeze_clk), 16'(model_freeze()));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wen     = '0;
    ren     = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 16'(valid), 16'h0);
    chk("rst_data", 16'(o_data), 16'h0);
    chk("rst_freeze", 16'(freeze_clk), 16'h0);
    @(posedge clk_i);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset_n = 1'b0;
    wen     = '0;
    ren     = 1'b0;
    for (int k = 0; k < 9; k++) din[k] = 8'h00;
    model_reset();
    @(posedge clk_i);
    #1;
    do_reset();

    // Idle after reset: nothing moves for 10 cycles.
    for (int i = 0; i < 10; i++) step();
    chk("idle_valid", 16'(valid), 16'h0);

    // Single word on channel 3, consumer not ready.
    wen = 9'h008; din[3] = 8'h5A; ren = 1'b0;
    step();
    chk("single_lat1", 16'(valid), 16'h0);
    wen = '0;
    step();
    chk("single_valid", 16'(valid), 16'h1);
    chk("single_data", 16'(o_data), 16'h5A);
    chk("single_f12", 16'(freeze_clk[12]), 16'(F_EN));
    step();
    step();
    ren = 1'b1;
    #1;
    chk("single_f12_ren", 16'(freeze_clk[12]), 16'h0);
    step();
    chk("single_drop", 16'(valid), 16'h0);
    ren = 1'b0;

    // Burst on all nine channels in one cycle.
    do_reset();
    wen = 9'h1FF; ren = 1'b1;
    for (int k = 0; k < 9; k++) din[k] = 8'(8'h10 + k);
    step();
    wen = '0;
    for (int k = 0; k < 9; k++) exp_q.push_back(8'(8'h10 + k));
    step();
    for (int k = 0; k < 9; k++) begin
      chk("burst_valid", 16'(valid), 16'h1);
      chk("burst_data", 16'(o_data), 16'(exp_q.pop_front()));
      step();
    end
    chk("burst_end", 16'(valid), 16'h0);

    // Round-robin between channels 0 and 5.
    do_reset();
    ren = 1'b0;
    for (int j = 0; j < 3; j++) begin
      wen = 9'h021; din[0] = 8'(8'hA0 + j); din[5] = 8'(8'hB0 + j);
      step();
    end
    wen = '0;
    exp_q = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
    ren = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk("rr_data", 16'(o_data), 16'(exp_q.pop_front()));
      step();
    end
    chk("rr_end", 16'(valid), 16'h0);
    ren = 1'b0;

    // Full and drop on channel 2 while the output holds a word.
    do_reset();
    wen = 9'h080; din[7] = 8'h77;
    step();
    wen = '0;
    step();
    for (int v = 1; v <= 5; v++) begin
      wen = 9'h004; din[2] = 8'(v);
      step();
      if (v == 3) chk("full_f2_3", 16'(freeze_clk[2]), 16'h0);
      if (v == 4) chk("full_f2_4", 16'(freeze_clk[2]), 16'(F_EN));
    end
    wen = '0;
    exp_q = '{8'h77, 8'h01, 8'h02, 8'h03, 8'h04};
    ren = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk("drain_data", 16'(o_data), 16'(exp_q.pop_front()));
      step();
    end
    chk("drain_end", 16'(valid), 16'h0);
    ren = 1'b0;

    // Asynchronous reset mid-stream.
    do_reset();
    wen = 9'h0C0; din[6] = 8'hE6; din[7] = 8'hE7;
    step();
    wen = '0;
    step();
    chk("mid_valid_pre", 16'(valid), 16'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_valid", 16'(valid), 16'h0);
    chk("mid_data", 16'(o_data), 16'h0);
    chk("mid_freeze", 16'(freeze_clk), 16'h0);
    model_reset();
    @(posedge clk_i);
    #1;
    reset_n = 1'b1;
    wen = 9'h050; din[4] = 8'h44; din[6] = 8'h66; ren = 1'b1;
    step();
    wen = '0;
    step();
    exp_q = '{8'h44, 8'h66};
    for (int j = 0; j < 2; j++) begin
      chk("post_data", 16'(o_data), 16'(exp_q.pop_front()));
      step();
    end
    chk("post_end", 16'(valid), 16'h0);

    // Random traffic: busy consumer, then slow consumer, then drain.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      wen = 9'($urandom) & 9'($urandom);
      for (int k = 0; k < 9; k++) din[k] = 8'($urandom_range(0, 255));
      ren = ($urandom_range(0, 3) != 0);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      wen = 9'($urandom);
      for (int k = 0; k < 9; k++) din[k] = 8'($urandom_range(0, 255));
      ren = ($urandom_range(0, 3) == 0);
      step();
    end
    wen = '0;
    ren = 1'b1;
    for (int i = 0; i < 45; i++) step();
    chk("final_empty", 16'(valid), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/top_9x1_arbiter.md
# top_9x1_arbiter

Nine-channel to one-channel byte merger with per-channel input FIFOs and round-robin arbitration. Each of nine producers pushes 8-bit words with a write strobe. The block drains the FIFOs into a single registered output stage that uses a valid/accept handshake. It also raises per-channel freeze requests so that upstream clock or event generators can stall producers whose FIFO is full.

## Interface
- DEPTH, 4: entries per channel FIFO; power of two, 2–16.
- clk_i  in  1  single clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wen  in  9  per-channel write strobe; bit k belongs to channel k.
- i_data0 … i_data8  in  8 each  channel write data; sampled when wen[k]=1.
- ren  in  1  consumer accept; a transfer occurs on an edge where valid=1 and ren=1.
- valid  out  1  o_data holds an unconsumed word.
- o_data  out  8  output word.
- freeze_clk  out  13  freeze requests: [8:0] per-channel full, [11:9] constant 0, [12] output stalled.

## Operation
- Per channel k: a circular FIFO of DEPTH×8 bits with a write pointer, a read pointer and a count (width log2(DEPTH)+1).
- Push: when wen[k]=1 and the FIFO is not full, or when it is full and the same channel is popped on the same edge.
- A push to a full FIFO that is not popped on that edge is dropped silently; FIFO state is unchanged.
- Pointers wrap modulo DEPTH.
- Output load condition: (valid=0 or ren=1) and at least one FIFO is non-empty.
- On load, the arbiter selects the first non-empty channel, searching last_grant+1, last_grant+2, … modulo 9.
- On load: pop that FIFO, register its head word into o_data, set valid=1, set last_grant to the selected channel.
- valid=1, ren=1 and no FIFO non-empty → valid clears; o_data keeps its last value.
- valid=1 and ren=0 → o_data and valid hold; no pop occurs.
- freeze_clk[k] (k<9) = FIFO k count == DEPTH. It is decoded from registered count, so it has no combinational path from wen.
- freeze_clk[12] = valid & ~ren. This is combinational from ren.
- Reset state: all FIFOs empty, last_grant = 8 (so channel 0 wins first), valid=0, o_data=0x00, freeze_clk=0.
- Reset asserted mid-operation discards all buffered data immediately.

## Timing
- wen[k] sampled at edge E → FIFO non-empty after E.
- Output empty, no competition → valid=1 with the word after edge E+1. Minimum latency is 2 edges.
- Back-to-back: with ren held at 1, one word is delivered per cycle.
- Output register refilled on the same edge it is accepted: no bubble.
- freeze_clk[k] asserts the cycle after the push that fills FIFO k. It deasserts the cycle after the first pop from it.
- Simultaneous pushes on all nine channels: all are accepted. They are delivered in round-robin order starting after last_grant, one per accepted cycle.

## Configuration
- TOP_9X1_FREEZE_EN defined: freeze_clk is driven as above.
- TOP_9X1_FREEZE_EN undefined: freeze_clk is tied to 13'h0000. The FIFO-full detection logic is still used internally for drop decisions.

## Test plan
- Reset then idle:
  - reset_n=0 → valid=0, o_data=0x00, freeze_clk=0.
  - reset_n released with wen=0 → outputs stay unchanged for 10 cycles.
- Single word:
  - wen[3]=1, i_data3=0x5A for one cycle, ren=0 → valid=1, o_data=0x5A two edges later.
  - freeze_clk[12]=1 until ren=1; valid drops the edge after acceptance.
- Burst on all channels:
  - One cycle with wen=9'h1FF, i_dataK=0x10+K, ren=1 → o_data sequence 0x10,0x11,…,0x18 on consecutive cycles, then valid=0.
- Round-robin fairness:
  - Channels 0 and 5 each loaded with 3 words (0xA0–A2, 0xB0–B2), ren=1 → output A0,B0,A1,B1,A2,B2.
- Full and drop (DEPTH=4, ren=0):
  - Five pushes to channel 2 with values 1–5 → freeze_clk[2]=1 after the 4th push.
  - Draining yields 1,2,3,4; value 5 is lost.
  - With the macro undefined, freeze_clk stays 0 throughout.
- Async reset mid-stream:
  - reset_n pulsed low between edges while valid=1 and FIFOs hold data → valid=0 immediately.
  - After release, only words written post-reset appear.
